// File: rtl/arm_mem_pkg.sv
// Shared types and constants for the MEM-stage controller that drives the external 16-bit SRAM.
package arm_mem_pkg;

  localparam int          SRAM_DW        = 16;
  localparam logic [31:0] BASE_ADDR_DEF  = 32'd1024;
  localparam logic [31:0] ALIGN_ERR_WORD = 32'hDEAD_BEEF;

  typedef enum logic [2:0] {
    IDLE,
    RD_LO,
    RD_HI,
    WR_LO,
    WR_HI,
    DONE
  } mem_state_e;

  function automatic logic is_phase(mem_state_e s);
    return (s == RD_LO) || (s == RD_HI) || (s == WR_LO) || (s == WR_HI);
  endfunction

endpackage

// File: rtl/sram_phase_timer.sv
// Per-phase wait timer: reloads to WAIT_CYCLES-1 on entry to a phase and flags the phase's last cycle.
module sram_phase_timer #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic last
);

  localparam int            CW       = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] LOAD_VAL = CW'(WAIT_CYCLES - 1);

  logic [CW-1:0] count;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= LOAD_VAL;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign last = (count == '0);

endmodule

// File: rtl/sram_controller.sv
// Sequences 32-bit MEM-stage accesses onto a 16-bit async SRAM as two halfword phases and freezes the pipeline.
// Optional build macro SRAM_ALIGN_CHK_EN adds misaligned-address detection and the err port.
module sram_controller
  import arm_mem_pkg::*;
#(
  parameter int          SRAM_AW     = 18,
  parameter int          WAIT_CYCLES = 1,
  parameter logic [31:0] BASE_ADDR   = BASE_ADDR_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_r_en,
  input  logic               mem_w_en,
  input  logic [31:0]        address,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  output logic               ready,
  output logic               freeze,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [SRAM_DW-1:0] sram_dq_out,
  output logic               sram_dq_oe,
  input  logic [SRAM_DW-1:0] sram_dq_in,
  output logic               sram_ce_n,
  output logic               sram_oe_n,
  output logic               sram_we_n,
  output logic               sram_ub_n,
  output logic               sram_lb_n
`ifdef SRAM_ALIGN_CHK_EN
  ,
  output logic               err
`endif
);

  mem_state_e         state, state_nxt;
  logic               req;
  logic               last;
  logic               load;
  logic               misaligned;
  logic               hi_half;
  logic [SRAM_AW-2:0] word_idx;

  assign req      = mem_r_en | mem_w_en;
  // Out-of-range addresses wrap: the cast keeps only the low SRAM_AW-1 word-index bits.
  assign word_idx = (SRAM_AW-1)'((address - BASE_ADDR) >> 2);
  assign hi_half  = (state == RD_HI) || (state == WR_HI);

`ifdef SRAM_ALIGN_CHK_EN
  logic err_q;

  assign misaligned = |address[1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (state == IDLE && req) begin
      err_q <= misaligned;
    end
  end

  assign err = (state == DONE) && err_q;
`else
  assign misaligned = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (req) begin
          if (misaligned)    state_nxt = DONE;
          else if (mem_w_en) state_nxt = WR_LO;
          else               state_nxt = RD_LO;
        end
      end
      RD_LO:   if (last) state_nxt = RD_HI;
      RD_HI:   if (last) state_nxt = DONE;
      WR_LO:   if (last) state_nxt = WR_HI;
      WR_HI:   if (last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Reload the timer on entry to each halfword phase, including the LO->HI hand-over.
  assign load = is_phase(state_nxt) && (state_nxt != state);

  sram_phase_timer #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_timer (
    .clk (clk),
    .rst (rst),
    .load(load),
    .last(last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (state == IDLE && req && misaligned) begin
      rdata <= ALIGN_ERR_WORD;
    end else if (state == RD_LO && last) begin
      rdata[15:0] <= sram_dq_in;
    end else if (state == RD_HI && last) begin
      rdata[31:16] <= sram_dq_in;
    end
  end

  always_comb begin
    sram_addr   = '0;
    sram_dq_out = '0;
    sram_dq_oe  = 1'b0;
    sram_ce_n   = 1'b1;
    sram_oe_n   = 1'b1;
    sram_we_n   = 1'b1;
    sram_ub_n   = 1'b1;
    sram_lb_n   = 1'b1;
    unique case (state)
      RD_LO, RD_HI: begin
        sram_addr = {word_idx, hi_half};
        sram_ce_n = 1'b0;
        sram_oe_n = 1'b0;
        sram_ub_n = 1'b0;
        sram_lb_n = 1'b0;
      end
      WR_LO, WR_HI: begin
        sram_addr   = {word_idx, hi_half};
        sram_ce_n   = 1'b0;
        sram_ub_n   = 1'b0;
        sram_lb_n   = 1'b0;
        sram_dq_oe  = 1'b1;
        sram_dq_out = hi_half ? wdata[31:16] : wdata[15:0];
        // With multi-cycle phases the last cycle lets we_n rise before the address moves.
        sram_we_n   = (WAIT_CYCLES > 1) ? last : 1'b0;
      end
      default: ;
    endcase
  end

  assign ready  = (state == DONE) || (state == IDLE && !req);
  assign freeze = req && !ready;

endmodule
